dbg_input_conditioner: RTL
==========================

Name: dbg_input_conditioner

Overview:
- Front end for the board debug inputs: 16 slide switches and one push button.
- Synchronises the raw pad inputs and debounces them, producing a glitch-free switch vector. The LED debug mux uses sw[15:8] as its page select; sw[15:0] is its pass-through default.
- Produces a one-cycle step pulse per button press, used as the manual-step clock enable (pclk source).
- Keeps a press counter that is viewable on the LEDs.

Parameters:
- WIDTH, 16, switch vector width.
- DB_CYCLES, 50000, number of consecutive identical synchronised samples required to accept a new value (1 ms at 50 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 16, width of each debounce counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- sw_raw  in  WIDTH  switch pads, asynchronous to clk.
- btn_raw  in  1  push-button pad, asynchronous, active-high when pressed.
- sw_out  out  WIDTH  debounced switch vector; feeds the LED debug mux and the CPU switch inputs.
- sw_changed  out  1  one-cycle pulse when sw_out takes a new value.
- btn_level  out  1  debounced button level.
- btn_pulse  out  1  one-cycle pulse on each debounced 0->1 transition of the button.
- press_cnt  out  16  count of btn_pulse events; wraps at 16 bits.

Behaviour:
- Reset (rst=0, asynchronous):
  - all sync flops, candidates, counters and outputs clear to 0;
  - sw_out=0, sw_changed=0, btn_level=0, btn_pulse=0, press_cnt=0.
- Synchroniser: two-flop chain per bit (s1, s2). No logic between the two flops.
- Switch debounce channel (one shared counter for the whole vector):
  - if s2 != cand: cand<=s2, cnt<=0 (any bit changing restarts the window);
  - else if cnt != DB_CYCLES-1: cnt<=cnt+1;
  - else (cnt==DB_CYCLES-1): cnt holds. If cand != sw_out, then sw_out<=cand and sw_changed<=1 for one cycle.
  - sw_changed is 0 on every other cycle.
- Latency: a pad change that is stable from sampling edge E onward appears on sw_out at edge E+DB_CYCLES+2.
- Bounce: a change that reverts before its window completes never reaches sw_out, and no sw_changed pulse is issued.
- Button channel: same structure, with its own cand_b and cnt_b counter. The committed value drives btn_level.
  - btn_pulse=1 for exactly one cycle when btn_level commits 0->1;
  - no pulse on a 1->0 commit.
- press_cnt increments by 1 in the same cycle btn_pulse is asserted. 16'hFFFF wraps to 16'h0000 with no flag.
- Holding the button: a continuously held button produces exactly one pulse; there is no auto-repeat.
- Simultaneous events: the switch and button channels are fully independent, so commits in the same cycle are both honoured.
- Reset mid-window: the pending candidate is discarded. After release, counting restarts from the current s2 against sw_out=0.
- All outputs are registered; there is no combinational path from the pads to any output.

Decomposition:
- Shared package/include: the constants DB_CYCLES_DEFAULT and DBG_SW_WIDTH, alongside the existing register/value width macros.
- One natural sub-module, dbg_debounce_ch (parameters W, DB_CYCLES, CNT_W; includes the synchroniser, cand, counter and commit logic).
  - Instance 1: W=WIDTH for the switch vector.
  - Instance 2: W=1 for the button.
  - The top level adds edge detection and press_cnt.

Test Plan (DB_CYCLES=4 unless stated):
1. Reset, then sw_raw=16'h1234 from edge 0 -> sw_out stays 0 through edge 5; sw_out=16'h1234 and sw_changed=1 at edge 6 only.
2. sw_raw toggles bit 8 every 3 cycles for 30 cycles, then settles at 16'h0100 -> no sw_out change during toggling; one commit to 16'h0100 exactly 6 edges after settling.
3. btn_raw held high for 20 cycles, released for 20, pressed again -> btn_pulse exactly twice, press_cnt=2, btn_level tracks with 6-cycle lag, no pulse on release.
4. Preload press_cnt to 16'hFFFF (65535 presses, or force in the bench), press once -> press_cnt=16'h0000, btn_pulse=1.
5. rst asserted asynchronously mid-window (cnt=2, sw_raw=16'hFFFF) -> outputs 0 immediately without waiting for a clock edge; after release, sw_out=16'hFFFF 6 edges later.
6. Button press and switch change committing on the same edge -> btn_pulse and sw_changed both 1 in that cycle.

Source files
------------

// File: rtl/dbg_input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// dbg_input_conditioner_pkg
//
// Shared constants for the board debug-input front end.
//
// Contents:
//   DBG_SW_WIDTH      - number of slide switches on the board
//   DB_CYCLES_DEFAULT - debounce window in clk cycles (1 ms at 50 MHz)
//   DBG_CNT_W         - width of each debounce window counter
//   DBG_PRESS_W       - width of the button press counter
// -----------------------------------------------------------------------------
package dbg_input_conditioner_pkg;

    localparam int DBG_SW_WIDTH      = 16;
    localparam int DB_CYCLES_DEFAULT = 50000;
    localparam int DBG_CNT_W         = 16;
    localparam int DBG_PRESS_W       = 16;

endpackage

// File: rtl/dbg_debounce_ch.sv
// -----------------------------------------------------------------------------
// dbg_debounce_ch
//
// One debounce channel. It takes a W-bit vector of asynchronous pad inputs
// through a two-flop synchroniser. It accepts a new value only after
// DB_CYCLES consecutive identical synchronised samples. One window counter
// is shared by the whole vector, so a change on any bit restarts the window.
//
// Parameters:
//   W         - vector width
//   DB_CYCLES - consecutive identical samples needed to commit (2..2^CNT_W-1)
//   CNT_W     - width of the window counter
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   din       in   W   raw pad inputs, asynchronous to clk
//   dout      out  W   committed (debounced) value, registered
//   changed   out  1   one-cycle pulse in the cycle dout takes a new value
//   rise_next out  W   bits that will commit 0->1 at the coming clock edge.
//                      The parent uses this to register edge events that line
//                      up with dout.
// -----------------------------------------------------------------------------
module dbg_debounce_ch
    import dbg_input_conditioner_pkg::*;
#(
    parameter int W         = 1,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = DBG_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         changed,
    output logic [W-1:0] rise_next
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [W-1:0]     s1;
    logic [W-1:0]     s2;
    logic [W-1:0]     cand;
    logic [CNT_W-1:0] cnt;
    logic             commit;

    // A commit happens only when all of these are true:
    //   - the window has completed;
    //   - the sample is still unchanged on this cycle;
    //   - the candidate actually differs from what is already committed.
    // When the window is full, cnt holds at CNT_LAST. A later change then
    // commits as soon as its own window completes.
    assign commit    = (s2 == cand) && (cnt == CNT_LAST) && (cand != dout);
    assign rise_next = commit ? (cand & ~dout) : '0;

    // The two flops are kept back to back with nothing in between. This gives
    // s1 a full cycle to resolve metastability.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Window tracking. A new sample value restarts the window from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand <= '0;
            cnt  <= '0;
        end else if (s2 != cand) begin
            cand <= s2;
            cnt  <= '0;
        end else if (cnt != CNT_LAST) begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

    // Committed value and its change strobe. changed is high only in the
    // cycle that follows a commit edge, so it lines up with the new dout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout    <= '0;
            changed <= 1'b0;
        end else begin
            changed <= commit;
            if (commit) begin
                dout <= cand;
            end
        end
    end

endmodule

// File: rtl/dbg_input_conditioner.sv
// -----------------------------------------------------------------------------
// dbg_input_conditioner
//
// Front end for the board debug inputs: 16 slide switches and one push button.
// Each input group is synchronised and debounced by its own independent
// channel. The button also produces a single-cycle step pulse per press, which
// serves as the manual-step clock enable. A wrapping press counter is kept for
// display on the LEDs.
//
// Parameters:
//   WIDTH     - switch vector width
//   DB_CYCLES - debounce window in clk cycles
//   CNT_W     - width of each debounce counter
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   sw_raw     in   WIDTH  switch pads (asynchronous)
//   btn_raw    in   1      push-button pad (asynchronous, high = pressed)
//   sw_out     out  WIDTH  debounced switches (LED mux page select / CPU inputs)
//   sw_changed out  1      one-cycle pulse when sw_out takes a new value
//   btn_level  out  1      debounced button level
//   btn_pulse  out  1      one-cycle pulse on each debounced press
//   press_cnt  out  16     number of presses, wraps silently
//
// Every output comes straight from a flop; no pad reaches an output through
// combinational logic.
// -----------------------------------------------------------------------------
module dbg_input_conditioner
    import dbg_input_conditioner_pkg::*;
#(
    parameter int WIDTH     = DBG_SW_WIDTH,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = DBG_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       sw_raw,
    input  logic                   btn_raw,
    output logic [WIDTH-1:0]       sw_out,
    output logic                   sw_changed,
    output logic                   btn_level,
    output logic                   btn_pulse,
    output logic [DBG_PRESS_W-1:0] press_cnt
);

    logic [WIDTH-1:0] sw_rise_unused;
    logic             btn_changed_unused;
    logic             btn_rise_next;

    dbg_debounce_ch #(
        .W         (WIDTH),
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_sw_ch (
        .clk       (clk),
        .rst       (rst),
        .din       (sw_raw),
        .dout      (sw_out),
        .changed   (sw_changed),
        .rise_next (sw_rise_unused)
    );

    dbg_debounce_ch #(
        .W         (1),
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_btn_ch (
        .clk       (clk),
        .rst       (rst),
        .din       (btn_raw),
        .dout      (btn_level),
        .changed   (btn_changed_unused),
        .rise_next (btn_rise_next)
    );

    // The pulse and the counter are both registered from the channel's
    // look-ahead rise flag. They therefore change on the same edge as
    // btn_level goes high. A release commit never sets the rise flag, so a
    // release produces no pulse. A held button commits only once, so holding
    // the button gives exactly one pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_pulse <= 1'b0;
            press_cnt <= '0;
        end else begin
            btn_pulse <= btn_rise_next;
            press_cnt <= press_cnt + DBG_PRESS_W'(btn_rise_next);
        end
    end

endmodule
